// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers, read-mode constants and the error-flag type shared by sync_fifo_flags.
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: WIDTH x DEPTH storage with a synchronous write port and a registered read port.
module sync_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
    end

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with standard/FWFT read, threshold flags, occupancy
// count and sticky overflow/underflow errors; all flags are registered.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          write_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          read_en,
    output logic [WIDTH-1:0]              data_out,
    output logic                          data_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [count_width(DEPTH)-1:0] count,
    input  logic                          clr_err,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
    localparam logic          IS_FWFT  = (FWFT == MODE_FWFT);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ae_q, ae_d;
    logic          af_q, af_d;
    err_flags_t    err_q, err_d;
    logic          push, pop, mem_rd, mem_has_word;

    // In FWFT the output register holds the head word: memory is read whenever that
    // register is free or being vacated, so count spans memory plus output register.
    always_comb begin
        push            = write_en && !full_q;
        pop             = read_en && !empty_q;
        mem_has_word    = wptr_q != rptr_q;
        mem_rd          = IS_FWFT ? (mem_has_word && (!valid_q || pop)) : pop;
        wptr_d          = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d          = mem_rd ? rptr_q + 1'b1 : rptr_q;
        count_d         = count_q + CW'(push) - CW'(pop);
        valid_d         = IS_FWFT ? (mem_rd || (valid_q && !pop)) : pop;
        empty_d         = IS_FWFT ? !valid_d : (count_d == '0);
        full_d          = count_d == FULL_CNT;
        af_d            = count_d >= AF_CNT;
        ae_d            = count_d <= AE_CNT;
        err_d.overflow  = (err_q.overflow && !clr_err) || (write_en && full_q);
        err_d.underflow = (err_q.underflow && !clr_err) || (read_en && empty_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            err_q   <= err_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (data_in),
        .rd_en   (mem_rd),
        .rd_addr (rptr_q[AW-1:0]),
        .rd_data (data_out)
    );

    assign data_valid   = valid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: standard and FWFT instances on shared stimulus, checked every cycle
// against queue-based reference models plus hand-computed directed expectations.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_dout, f_dout;
    logic       s_dv, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic       f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [2:0] s_count, f_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(2), .AE_THRESH(2)) u_std (
        .clk(clk), .rstn(rstn), .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_out(s_dout), .data_valid(s_dv), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count), .clr_err(clr_err),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rstn(rstn), .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_out(f_dout), .data_valid(f_dv), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count), .clr_err(clr_err),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Reference models: a queue of words held; FWFT head is visible once it was already
    // held before the most recent edge.
    logic [7:0] sq[$];
    logic [7:0] fq[$];
    logic [7:0] s_last = '0;
    logic s_dv_m = 0, s_ovf_m = 0, s_unf_m = 0;
    logic f_valid_m = 0, f_ovf_m = 0, f_unf_m = 0;
    logic s_push, s_pop, f_push, f_pop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sq.delete(); fq.delete();
            s_last = '0; s_dv_m = 0; s_ovf_m = 0; s_unf_m = 0;
            f_valid_m = 0; f_ovf_m = 0; f_unf_m = 0;
        end else begin
            s_push  = write_en && sq.size() < 4;
            s_pop   = read_en && sq.size() > 0;
            s_ovf_m = (s_ovf_m && !clr_err) || (write_en && sq.size() == 4);
            s_unf_m = (s_unf_m && !clr_err) || (read_en && sq.size() == 0);
            s_dv_m  = s_pop;
            if (s_pop) s_last = sq.pop_front();
            if (s_push) sq.push_back(data_in);
            f_push  = write_en && fq.size() < 4;
            f_pop   = read_en && f_valid_m;
            f_ovf_m = (f_ovf_m && !clr_err) || (write_en && fq.size() == 4);
            f_unf_m = (f_unf_m && !clr_err) || (read_en && !f_valid_m);
            if (f_pop) void'(fq.pop_front());
            f_valid_m = fq.size() > 0;
            if (f_push) fq.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        chk("s_count", s_count, sq.size());
        chk("s_empty", s_empty, sq.size() == 0);
        chk("s_full", s_full, sq.size() == 4);
        chk("s_almost_empty", s_ae, sq.size() <= 2);
        chk("s_almost_full", s_af, sq.size() >= 2);
        chk("s_overflow", s_ovf, s_ovf_m);
        chk("s_underflow", s_unf, s_unf_m);
        chk("s_data_valid", s_dv, s_dv_m);
        chk("s_data_out", s_dout, s_last);
        chk("f_count", f_count, fq.size());
        chk("f_empty", f_empty, !f_valid_m);
        chk("f_full", f_full, fq.size() == 4);
        chk("f_almost_empty", f_ae, fq.size() <= 1);
        chk("f_almost_full", f_af, fq.size() >= 3);
        chk("f_overflow", f_ovf, f_ovf_m);
        chk("f_underflow", f_unf, f_unf_m);
        chk("f_data_valid", f_dv, f_valid_m);
        if (f_valid_m) chk("f_data_out", f_dout, fq[0]);
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        write_en = w;
        data_in  = d;
        read_en  = r;
        clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pops [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        #1 rstn = 1'b0;
        #2;
        chk("rst_count", s_count, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_full", s_full, 0);
        chk("rst_ae", s_ae, 1);
        chk("rst_af", s_af, 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_f_dv", f_dv, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
        chk("fill_full", s_full, 1);
        chk("fill_count", s_count, 4);
        chk("fill_af", s_af, 1);
        step(1, 8'h55, 0, 0);
        chk("ovf_set", s_ovf, 1);
        chk("ovf_count", s_count, 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, 0);
            chk("pop_dv", s_dv, 1);
            chk("pop_data", s_dout, pops[i]);
        end
        step(0, 8'h00, 0, 0);
        chk("dv_pulse_end", s_dv, 0);
        chk("dout_hold", s_dout, 8'h44);

        step(0, 8'h00, 1, 0);
        chk("unf_set", s_unf, 1);
        chk("unf_count", s_count, 0);
        chk("unf_dv", s_dv, 0);
        step(0, 8'h00, 1, 1);
        chk("unf_set_wins", s_unf, 1);
        step(0, 8'h00, 0, 1);
        chk("unf_cleared", s_unf, 0);
        chk("ovf_cleared", s_ovf, 0);

        step(1, 8'd1, 0, 0); step(1, 8'd2, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 8'(i + 3), 1, 0);
            chk("wrap_count", s_count, 2);
            chk("wrap_data", s_dout, i + 1);
        end
        step(1, 8'd15, 0, 0); step(1, 8'd16, 0, 0);
        chk("wrap_full", s_full, 1);
        step(1, 8'd17, 1, 0);
        chk("full_pushpop_count", s_count, 3);
        chk("full_pushpop_ovf", s_ovf, 1);
        chk("full_pushpop_data", s_dout, 8'd13);

        #1 rstn = 1'b0;
        #1;
        chk("async_count", s_count, 0);
        chk("async_empty", s_empty, 1);
        chk("async_ovf", s_ovf, 0);
        chk("async_f_count", f_count, 0);
        #1 rstn = 1'b1;

        step(1, 8'hA5, 0, 0);
        chk("fwft_lat_dv", f_dv, 0);
        chk("fwft_lat_empty", f_empty, 1);
        chk("fwft_lat_count", f_count, 1);
        step(0, 8'h00, 0, 0);
        chk("fwft_dv", f_dv, 1);
        chk("fwft_data", f_dout, 8'hA5);
        step(0, 8'h00, 1, 0);
        chk("fwft_drain_dv", f_dv, 0);
        chk("fwft_drain_empty", f_empty, 1);
        chk("post_rst_std_data", s_dout, 8'hA5);
        chk("post_rst_std_dv", s_dv, 1);

        for (int i = 0; i < 2000; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            if ($urandom_range(0, 399) == 0) begin
                rstn = 1'b0;
                #1 rstn = 1'b1;
            end
            step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
